// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode and FSM state enums.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        ADD = 4'b0000,
        SUB = 4'b0001,
        AND = 4'b0010,
        NOR = 4'b0011,
        XOR = 4'b0100,
        LSH = 4'b0101,
        RSH = 4'b0110,
        SEQ = 4'b0111,
        SNE = 4'b1000,
        SGT = 4'b1001,
        SLT = 4'b1010,
        MUL = 4'b1011
    } op_t;

    localparam logic [3:0] kMUL = 4'b1011;

    // Named states so they show up symbolically in waveforms
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-read stage, the ALU and writeback.
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         err;

    // Producer side: offers operations and consumes results
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, zero, err
    );

    // ALU side
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, zero, err
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for W cycles.
// Only instantiated when ALU_MUL_EN is defined.
// o_prod is the accumulator value after the current step, so the final
// product is available in the same cycle o_done is high.
module alu_mul_iter #(
    parameter int W = 8
) (
    input  logic           CLK,
    input  logic           reset_n,
    input  logic           i_start,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic           o_done,
    output logic [2*W-1:0] o_prod
);
    localparam int CW = $clog2(W) + 1;

    logic           r_run;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_prod    = w_acc_nxt;
    assign o_done    = r_run && (r_cnt == CW'(W - 1));

    // Load operands on start, then add/shift once per cycle until the last step
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_run    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_mcand  <= {{W{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_run) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (o_done)
                r_run <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with optional iterative MUL.
// Build macro: ALU_MUL_EN -- when defined, opcode 1011 multiplies over W cycles;
// otherwise 1011 is an illegal opcode like 1100-1111.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input logic       CLK,
    input logic       reset_n,
    alu_seq_if.slave  bus
);
    localparam logic [W-1:0] kWIDTH = W'(W);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_in_ready;
    logic           w_accept;
    logic           w_is_mul;
    logic           w_load;

    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_res;
    logic           w_carry;
    logic           w_err;

    logic           w_mul_done;
    logic [2*W-1:0] w_mul_prod;

    logic [W-1:0]   w_out_res;
    logic           w_out_carry;
    logic           w_out_err;

    logic [W-1:0]   r_result;
    logic           r_carry;
    logic           r_zero;
    logic           r_err;

    // Accepting while DONE relies on the consumer taking the held result now
    assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

`ifdef ALU_MUL_EN
    assign w_is_mul = (bus.op == kMUL);

    alu_mul_iter #(.W(W)) u_mul (
        .CLK     (CLK),
        .reset_n (reset_n),
        .i_start (w_accept && w_is_mul),
        .i_a     (bus.a),
        .i_b     (bus.b),
        .o_done  (w_mul_done),
        .o_prod  (w_mul_prod)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_prod = '0;
`endif

    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

    // Single-cycle datapath; anything not listed (incl. MUL here) is illegal
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (bus.op)
            ADD: begin
                w_res   = w_sum[W-1:0];
                w_carry = w_sum[W];
            end
            SUB: begin
                w_res   = w_diff[W-1:0];
                w_carry = w_diff[W];
            end
            AND: w_res = bus.a & bus.b;
            NOR: w_res = ~(bus.a | bus.b);
            XOR: w_res = bus.a ^ bus.b;
            LSH: w_res = (bus.b < kWIDTH) ? (bus.a << bus.b) : '0;
            RSH: w_res = (bus.b < kWIDTH) ? (bus.a >> bus.b) : '0;
            SEQ: w_res = {{(W-1){1'b0}}, bus.a == bus.b};
            SNE: w_res = {{(W-1){1'b0}}, bus.a != bus.b};
            SGT: w_res = {{(W-1){1'b0}}, bus.a >  bus.b};
            SLT: w_res = {{(W-1){1'b0}}, bus.a <  bus.b};
            default: w_err = 1'b1;
        endcase
    end

    assign w_out_res   = (r_state == BUSY) ? w_mul_prod[W-1:0]     : w_res;
    assign w_out_carry = (r_state == BUSY) ? |w_mul_prod[2*W-1:W]  : w_carry;
    assign w_out_err   = (r_state == BUSY) ? 1'b0                  : w_err;

    // Output registers move only on entry into DONE
    assign w_load = ((r_state == BUSY) && w_mul_done) || (w_accept && !w_is_mul);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_nxt = w_is_mul ? BUSY : DONE;
            end
            BUSY: begin
                if (w_mul_done)
                    w_state_nxt = DONE;
            end
            DONE: begin
                if (w_accept)
                    w_state_nxt = w_is_mul ? BUSY : DONE;
                else if (bus.out_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Result/flag registers; zero is derived from the value being registered
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_load) begin
            r_result <= w_out_res;
            r_carry  <= w_out_carry;
            r_zero   <= (w_out_res == '0);
            r_err    <= w_out_err;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.carry     = r_carry;
    assign bus.zero      = r_zero;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops push expectations, a negedge
// monitor pops and compares whenever a result is handed off.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.W(W)) bus ();

    alu_seq #(.W(W)) dut (
        .CLK     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         e;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;
    int   w;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the accept edge, in_valid left high
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic c, input logic z, input logic e,
                        input string nm, input bit push, output int waited);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        waited       = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready)
            chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
        if (push)
            sb.push_back('{res: r, c: c, z: z, e: e, name: nm});
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every handed-off result against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got res=%0h with no pending expectation", bus.result);
            end else begin
                mon_e = sb.pop_front();
                if (bus.result !== mon_e.res || bus.carry !== mon_e.c ||
                    bus.zero !== mon_e.z || bus.err !== mon_e.e) begin
                    fails++;
                    $display("FAIL %s: got res=%0h c=%0b z=%0b e=%0b expected res=%0h c=%0b z=%0b e=%0b",
                             mon_e.name, bus.result, bus.carry, bus.zero, bus.err,
                             mon_e.res, mon_e.c, mon_e.z, mon_e.e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result",    bus.result,    0);
        chk("rst_carry",     bus.carry,     0);
        chk("rst_zero",      bus.zero,      0);
        chk("rst_err",       bus.err,       0);
        chk("rst_in_ready",  bus.in_ready,  1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops, back-to-back with out_ready high
        send(4'b0000, 8'hF0, 8'h20, 8'h10, 1, 0, 0, "add_f0_20", 1, w);
        send(4'b0001, 8'd5,  8'd5,  8'h00, 0, 1, 0, "sub_5_5",   1, w);
        chk("sub1_no_stall", w, 0);
        send(4'b0001, 8'd3,  8'd7,  8'hFC, 1, 0, 0, "sub_3_7",   1, w);
        chk("sub2_no_stall", w, 0);
        send(4'b0101, 8'h81, 8'd1,  8'h02, 0, 0, 0, "lsh_81_1",  1, w);
        send(4'b0101, 8'h81, 8'd8,  8'h00, 0, 1, 0, "lsh_b_eq_w", 1, w);
        send(4'b0110, 8'h80, 8'd7,  8'h01, 0, 0, 0, "rsh_80_7",  1, w);
        send(4'b0010, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, "and",       1, w);
        send(4'b0011, 8'h0F, 8'hF0, 8'h00, 0, 1, 0, "nor",       1, w);
        send(4'b0100, 8'hAA, 8'hFF, 8'h55, 0, 0, 0, "xor",       1, w);
        send(4'b0111, 8'd7,  8'd7,  8'h01, 0, 0, 0, "seq",       1, w);
        send(4'b1000, 8'd7,  8'd7,  8'h00, 0, 1, 0, "sne",       1, w);
        send(4'b1001, 8'd9,  8'd2,  8'h01, 0, 0, 0, "sgt",       1, w);
        send(4'b1010, 8'd9,  8'd2,  8'h00, 0, 1, 0, "slt_false", 1, w);
        send(4'b0000, 8'hFF, 8'h01, 8'h00, 1, 1, 0, "add_wrap",  1, w);
        send(4'b1111, 8'h12, 8'h34, 8'h00, 0, 1, 1, "illegal_f", 1, w);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;

        // MUL 20*13 = 260
`ifdef ALU_MUL_EN
        send(kMUL, 8'd20, 8'd13, 8'h04, 1, 0, 0, "mul_20_13", 1, w);
        bus.in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("mul_busy_in_ready",  bus.in_ready,  0);
            chk("mul_busy_out_valid", bus.out_valid, 0);
        end
        @(negedge clk);
        chk("mul_done_out_valid", bus.out_valid, 1);
`else
        send(kMUL, 8'd20, 8'd13, 8'h00, 0, 1, 1, "mul_disabled", 1, w);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mul_disabled_out_valid", bus.out_valid, 1);
`endif
        @(posedge clk); #1;

        // Backpressure: SLT result held while out_ready low
        bus.out_ready = 1'b0;
        send(4'b1010, 8'd2, 8'd9, 8'h01, 0, 0, 0, "slt_2_9", 1, w);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_result",    bus.result,    1);
            chk("bp_in_ready",  bus.in_ready,  0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(4'b1110, 8'd1, 8'd1, 8'h00, 0, 1, 1, "illegal_e_after_bp", 1, w);
        chk("bp_release_same_cycle_accept", w, 0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a MUL discards it
`ifdef ALU_MUL_EN
        send(kMUL, 8'd20, 8'd13, 8'h00, 0, 0, 0, "mul_aborted", 0, w);
`else
        send(kMUL, 8'd20, 8'd13, 8'h00, 0, 1, 1, "mul_disabled2", 1, w);
`endif
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_result",    bus.result,    0);
        chk("midrst_carry",     bus.carry,     0);
        chk("midrst_zero",      bus.zero,      0);
        chk("midrst_err",       bus.err,       0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("postrst_no_out_valid", bus.out_valid, 0);
            chk("postrst_in_ready",     bus.in_ready,  1);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the basic processor's combinational ALU. It executes the 4-bit opcode set on W-bit operands and registers every result. It adds an iterative multi-cycle MUL and flags carry, zero and illegal opcodes. It sits between the decode/register-read stage and writeback, and stalls the upstream stage through valid/ready.

## Interface
- W, 8, operand/result width (≥ 4, power of two)
- CLK  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept this cycle
- op  in  4  opcode (op_t)
- a, b  in  W  operands
- out_valid  out  1  result registered and pending
- out_ready  in  1  consumer takes result
- result  out  W  result
- carry  out  1  carry/borrow/overflow flag
- zero  out  1  result == 0
- err  out  1  illegal/unsupported opcode

## Operation
- States: IDLE, BUSY (MUL iterating), DONE (result held).
- Accept: in_valid && in_ready at a rising edge.
- Single-cycle ops go to DONE with the result registered. MUL goes to BUSY.
- Opcode semantics:
  - ADD 0000: a+b. carry = bit W of the sum.
  - SUB 0001: a−b. carry = 1 iff a<b (borrow).
  - AND 0010: a&b.
  - NOR 0011: ~(a|b).
  - XOR 0100: a^b.
  - LSH 0101: a<<b.
  - RSH 0110: a>>b (logical).
  - SEQ 0111, SNE 1000, SGT 1001, SLT 1010: unsigned compares; result = {W−1 zeros, compare bit}.
  - MUL 1011: low W bits of a*b. carry = 1 iff the high W bits are nonzero.
- For every op other than ADD, SUB and MUL, carry = 0.
- Shift amount is the full b value. If b ≥ W, the result is 0.
- Opcodes 1100–1111: result 0, err=1, completes as a single-cycle op.
- zero is computed from the registered result for every op, including err cases.
- BUSY: one shift-add step per cycle for exactly W cycles, then DONE.
- DONE: result, carry, zero and err are held stable while out_valid && !out_ready.
- DONE with out_ready:
  - If a new op is accepted in the same cycle, the state becomes that op's next state.
  - Otherwise the state returns to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). The combinational out_ready→in_ready path is intended.
- Inputs are sampled only at accept. Changes to a, b or op during BUSY have no effect.

## Timing
- Reset (async, any state, including mid-MUL):
  - State goes to IDLE and in-flight work is discarded; no output is produced.
  - out_valid=0, result=0, carry=0, zero=0, err=0.
- Single-cycle op latency: out_valid rises 1 cycle after accept.
- MUL latency: out_valid rises W+1 cycles after accept. in_ready=0 throughout BUSY.
- Back-to-back single-cycle ops with out_ready held high sustain 1 op/cycle.
- Output registers update only on the cycle of a state transition into DONE.

## Configuration
- ALU_MUL_EN defined: MUL is implemented as specified and the multiplier sub-module is instantiated.
- ALU_MUL_EN undefined:
  - Opcode 1011 is treated as illegal: result 0, err=1, 1-cycle latency.
  - BUSY is unreachable and the multiplier is not instantiated.

## Structure
- The shared definitions package holds:
  - the op_t enum (ADD … SLT, MUL) and kMUL = 4'b1011;
  - the state enum {IDLE, BUSY, DONE}, so state names appear in waveforms.
- Sub-module alu_mul_iter:
  - Parametrised by W; start/done interface.
  - Holds the multiplicand, multiplier and 2W accumulator, plus a $clog2(W)+1-bit step counter.
  - Reset through reset_n.
- alu_seq holds the FSM, the combinational single-cycle datapath and the output registers.

## Test plan
- W=8, ADD a=8'hF0 b=8'h20, out_ready=1 → after 1 cycle: result 8'h10, carry=1, zero=0, err=0.
- SUB a=5 b=5, then SUB a=3 b=7 back-to-back:
  - first result 0, zero=1, carry=0;
  - second result 8'hFC, carry=1;
  - in_ready stays 1 throughout.
- LSH a=8'h81 b=1 → 8'h02; LSH b=8 → 0; RSH a=8'h80 b=7 → 8'h01.
- MUL a=8'd20 b=8'd13 (ALU_MUL_EN):
  - in_ready=0 for 8 cycles; out_valid in cycle 9;
  - result 8'h04, carry=1 (260).
  - Without the macro: result 0, err=1 after 1 cycle.
- Backpressure: SLT a=2 b=9 with out_ready=0 for 5 cycles:
  - result=1 is held and in_ready=0;
  - then out_ready=1 with in_valid=1 (op 4'b1110) → that op is accepted the same cycle, next result 0, err=1.
- Assert reset_n=0 in cycle 4 of a MUL → outputs 0 immediately, in_ready=1 after release, no stale out_valid.
